video_int_gen: RTL and testbench
================================

Name: video_int_gen

Overview:
- Raster interrupt generator that sits directly downstream of the video port register block.
- Consumes the latched hint_beg/vint_beg and the INT mask, and tracks raster position from line/frame/column strobes.
- Produces int_start, which feeds back to the port block to auto-advance vint_beg.
- Drives the Z80 /INT line with prioritised frame, line and DMA interrupts, plus the im2 vector low byte.

Parameters:
INT_LEN, 32, /INT assertion window in Z80 clock-enable ticks before a timed-out frame request is dropped
VCNT_MAX, 319, last valid line number; vcnt saturates here if frame_start is missing

Ports:
clk  in  1  system clock
res_n  in  1  asynchronous active-low reset
zclk_tick  in  1  one-clk pulse per Z80 T-state
line_start  in  1  one-clk pulse at start of every raster line
frame_start  in  1  one-clk pulse at start of line 0; coincides with a line_start
col_tick  in  1  one-clk pulse per 8 pixels within a line
hint_beg  in  8  horizontal INT position, in col_tick units
vint_beg  in  9  vertical frame-INT line
intmask  in  3  enables: bit0 frame, bit1 line, bit2 DMA
dma_end  in  1  one-clk pulse when a DMA transfer completes
intack  in  1  one-clk pulse on the Z80 M1+IORQ acknowledge cycle
int_start  out  1  one-clk pulse when the frame INT fires, to the port block
int_n  out  1  Z80 /INT, active low
int_vect  out  8  im2 vector low byte for the highest pending source
pend  out  3  pending flags {dma, line, frame}, for status readback

Behaviour:
- Reset values (res_n low, asynchronous): hcnt=0, vcnt=0, pend=0, int_start=0, int_n=1, int_vect=8'hFF, len_cnt=0.
- hcnt (8 bit):
  - cleared on line_start;
  - otherwise +1 on col_tick, saturating at 255.
- vcnt (9 bit):
  - cleared on frame_start;
  - otherwise +1 on line_start, saturating at VCNT_MAX.
- Comparison point: the col_tick clock with hcnt==hint_beg, evaluated using pre-increment values.
- Frame event: at the comparison point when vcnt==vint_beg.
  - int_start pulses high on the next clk edge, for exactly 1 clk.
  - int_start pulses regardless of intmask[0], so vint_beg auto-increment keeps working.
  - pend[0] is set only if intmask[0]=1.
- Line event: at the comparison point on every line where vcnt!=vint_beg; sets pend[1] if intmask[1]=1.
- DMA event: dma_end sets pend[2] if intmask[2]=1.
- All pend updates are registered: 1 clk latency from the event strobe.
- Mask clear: when an intmask bit is 0, the matching pend bit is cleared every clk.
- int_n is low whenever pend!=0; it is registered from next-state pend, so it falls on the same edge pend sets.
- int_vect is combinational from pend, by priority:
  - frame → 8'hFF;
  - else line → 8'hFD;
  - else DMA → 8'hFB;
  - none → 8'hFF.
- intack clears the highest-priority pending bit only; lower bits stay pending, so int_n stays low.
- Timer and frame timeout:
  - len_cnt (6 bit) is cleared when pend[0] sets, and counts zclk_tick while pend[0]=1.
  - When len_cnt reaches INT_LEN-1 on a zclk_tick, pend[0] clears (frame INT not taken).
  - Line and DMA requests never time out.
- Simultaneous events:
  - same-source set and clear (ack, timeout) in one clk → set wins, len_cnt restarts.
  - intack with pend==0 → ignored.
  - frame and line events cannot coincide, by construction.
- If frame_start and col_tick arrive in the same clk, the counter clear wins.
- Reset mid-INT: int_n returns high asynchronously and all pending requests are lost.

Decomposition:
- Shared video package holds:
  - vector constants VEC_FRAME=8'hFF, VEC_LINE=8'hFD, VEC_DMA=8'hFB;
  - intmask bit indices IM_FRAME=0, IM_LINE=1, IM_DMA=2.
- One natural sub-module, video_raster_pos: the hcnt/vcnt counters plus the hit comparators, with outputs frame_hit and line_hit.
- Pending, priority and timeout logic stays in the top.

Test Plan:
- Reset release with intmask=3'b001, vint_beg=0, hint_beg=1:
  - frame_start followed by 2 col_ticks → one int_start pulse;
  - int_n low and int_vect=8'hFF;
  - with no intack, int_n rises after exactly 32 zclk_ticks.
- intmask=3'b000, vint_beg=5 → int_start still pulses once on line 5; int_n stays high; pend=0.
- intmask=3'b010, hint_beg=3:
  - each line sets pend[1] at the 4th col_tick, with int_vect=8'hFD;
  - intack clears it; no timeout is observed after 100 zclk_ticks.
- Frame and DMA both pending (dma_end, then frame hit):
  - int_vect=8'hFF;
  - first intack → pend=3'b100, int_vect=8'hFB, int_n still low;
  - second intack → int_n=1.
- dma_end and intack in the same clk with pend=3'b100 → pend stays 3'b100.
- Mask clear: intmask bit2 dropped while pend[2]=1 → pend cleared on the next clk.
- res_n pulsed low while int_n is low → int_n=1 and pend=0 immediately (asynchronously), hcnt=vcnt=0.

Source files
------------

// File: rtl/video_int_gen_pkg.sv
// Shared video definitions for the raster interrupt generator.
// Contents:
//   - im2 vector low bytes, one per interrupt source.
//   - intmask / pend bit indices.
//   - pick_vect(): vector for the highest-priority pending source.
`timescale 1ns/1ps
package video_int_gen_pkg;

  localparam logic [7:0] VEC_FRAME = 8'hFF;
  localparam logic [7:0] VEC_LINE  = 8'hFD;
  localparam logic [7:0] VEC_DMA   = 8'hFB;

  localparam int unsigned IM_FRAME = 0;
  localparam int unsigned IM_LINE  = 1;
  localparam int unsigned IM_DMA   = 2;

  // Priority is frame > line > DMA. With nothing pending the vector idles at
  // 8'hFF, which is the floating-bus value.
  function automatic logic [7:0] pick_vect(input logic [2:0] p);
    if (p[IM_FRAME])    return VEC_FRAME;
    else if (p[IM_LINE]) return VEC_LINE;
    else if (p[IM_DMA])  return VEC_DMA;
    else                 return 8'hFF;
  endfunction

endpackage

// File: rtl/video_raster_pos.sv
// Raster position tracker with interrupt-position comparators.
// Ports:
//   clk, res_n  : clock and asynchronous active-low reset
//   line_start  : clears hcnt, advances vcnt (saturating at VCNT_MAX)
//   frame_start : clears vcnt
//   col_tick    : advances hcnt (saturating at 255)
//   hint_beg    : horizontal compare position, in col_tick units
//   vint_beg    : frame interrupt line
//   frame_hit   : compare point reached on the frame-INT line (combinational)
//   line_hit    : compare point reached on any other line (combinational)
`timescale 1ns/1ps
module video_raster_pos
  import video_int_gen_pkg::*;
#(
  parameter int unsigned VCNT_MAX = 319
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       col_tick,
  input  logic [7:0] hint_beg,
  input  logic [8:0] vint_beg,
  output logic       frame_hit,
  output logic       line_hit
);

  localparam logic [8:0] VMAX = 9'(VCNT_MAX);

  logic [7:0] hcnt;
  logic [8:0] vcnt;
  logic       at_col;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hcnt <= '0;
    end else if (line_start) begin
      hcnt <= '0;
    end else if (col_tick && hcnt != '1) begin
      hcnt <= hcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      vcnt <= '0;
    end else if (frame_start) begin
      vcnt <= '0;
    end else if (line_start && vcnt != VMAX) begin
      vcnt <= vcnt + 9'd1;
    end
  end

  // Compare against the counters as they stand before this tick's increment.
  always_comb begin
    at_col    = col_tick && (hcnt == hint_beg);
    frame_hit = at_col && (vcnt == vint_beg);
    line_hit  = at_col && (vcnt != vint_beg);
  end

endmodule

// File: rtl/video_int_gen.sv
// Raster interrupt generator: prioritised frame/line/DMA requests on Z80 /INT.
// Ports:
//   clk, res_n   : clock and asynchronous active-low reset
//   zclk_tick    : one pulse per Z80 T-state, times the frame request window
//   line_start, frame_start, col_tick : raster strobes
//   hint_beg, vint_beg : interrupt position from the port block
//   intmask      : source enables {dma, line, frame}
//   dma_end      : DMA completion strobe
//   intack       : Z80 interrupt acknowledge strobe
//   int_start    : one-clk pulse on every frame hit (mask-independent)
//   int_n        : Z80 /INT, active low
//   int_vect     : im2 vector low byte of the highest pending source
//   pend         : pending flags {dma, line, frame}
`timescale 1ns/1ps
module video_int_gen
  import video_int_gen_pkg::*;
#(
  parameter int unsigned INT_LEN  = 32,
  parameter int unsigned VCNT_MAX = 319
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       zclk_tick,
  input  logic       line_start,
  input  logic       frame_start,
  input  logic       col_tick,
  input  logic [7:0] hint_beg,
  input  logic [8:0] vint_beg,
  input  logic [2:0] intmask,
  input  logic       dma_end,
  input  logic       intack,
  output logic       int_start,
  output logic       int_n,
  output logic [7:0] int_vect,
  output logic [2:0] pend
);

  localparam logic [5:0] LEN_LAST = 6'(INT_LEN - 1);

  logic       frame_hit;
  logic       line_hit;
  logic [2:0] set_req;
  logic [2:0] ack_clr;
  logic       timeout;
  logic [2:0] pend_nxt;
  logic [5:0] len_cnt;

  video_raster_pos #(
    .VCNT_MAX(VCNT_MAX)
  ) u_pos (
    .clk        (clk),
    .res_n      (res_n),
    .line_start (line_start),
    .frame_start(frame_start),
    .col_tick   (col_tick),
    .hint_beg   (hint_beg),
    .vint_beg   (vint_beg),
    .frame_hit  (frame_hit),
    .line_hit   (line_hit)
  );

  // Clears are applied before sets so a same-clk set always wins; the
  // final mask AND clears any disabled source every clk.
  always_comb begin
    set_req           = '0;
    set_req[IM_FRAME] = frame_hit;
    set_req[IM_LINE]  = line_hit;
    set_req[IM_DMA]   = dma_end;

    ack_clr = '0;
    if (intack) begin
      if (pend[IM_FRAME])     ack_clr[IM_FRAME] = 1'b1;
      else if (pend[IM_LINE]) ack_clr[IM_LINE]  = 1'b1;
      else if (pend[IM_DMA])  ack_clr[IM_DMA]   = 1'b1;
    end

    timeout  = pend[IM_FRAME] && zclk_tick && (len_cnt == LEN_LAST);

    pend_nxt = pend & ~ack_clr;
    if (timeout) pend_nxt[IM_FRAME] = 1'b0;
    pend_nxt = (pend_nxt | set_req) & intmask;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pend      <= '0;
      int_n     <= 1'b1;
      int_start <= 1'b0;
      len_cnt   <= '0;
    end else begin
      pend      <= pend_nxt;
      int_n     <= ~|pend_nxt;
      int_start <= frame_hit;
      if (set_req[IM_FRAME] && intmask[IM_FRAME]) begin
        len_cnt <= '0;
      end else if (pend[IM_FRAME] && zclk_tick) begin
        len_cnt <= timeout ? '0 : len_cnt + 6'd1;
      end
    end
  end

  assign int_vect = pick_vect(pend);

endmodule

// File: tb/tb_video_int_gen.sv
// Directed bench for video_int_gen: a vector table of one-clk input records
// with expected outputs after the edge, plus a hand sequence for async reset.
`timescale 1ns/1ps
module tb_video_int_gen;

  logic       clk = 1'b0;
  logic       res_n;
  logic       zclk_tick, line_start, frame_start, col_tick, dma_end, intack;
  logic [7:0] hint_beg;
  logic [8:0] vint_beg;
  logic [2:0] intmask;
  logic       int_start, int_n;
  logic [7:0] int_vect;
  logic [2:0] pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_int_gen #(.INT_LEN(32), .VCNT_MAX(319)) dut (
    .clk(clk), .res_n(res_n), .zclk_tick(zclk_tick), .line_start(line_start),
    .frame_start(frame_start), .col_tick(col_tick), .hint_beg(hint_beg),
    .vint_beg(vint_beg), .intmask(intmask), .dma_end(dma_end), .intack(intack),
    .int_start(int_start), .int_n(int_n), .int_vect(int_vect), .pend(pend)
  );

  typedef struct {
    string      name;
    logic       fr, ln, col, dma, ack, zt;
    logic [2:0] im;
    logic [7:0] hb;
    logic [8:0] vb;
    logic       e_st, e_n;
    logic [7:0] e_vect;
    logic [2:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic fr, logic ln, logic col,
                              logic dma, logic ack, logic zt, logic [2:0] im,
                              logic [7:0] hb, logic [8:0] vb, logic e_st,
                              logic e_n, logic [7:0] e_vect, logic [2:0] e_pend);
    vec_t v;
    v.name = name; v.fr = fr; v.ln = ln; v.col = col; v.dma = dma; v.ack = ack;
    v.zt = zt; v.im = im; v.hb = hb; v.vb = vb; v.e_st = e_st; v.e_n = e_n;
    v.e_vect = e_vect; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    frame_start = v.fr; line_start = v.ln; col_tick = v.col;
    dma_end = v.dma; intack = v.ack; zclk_tick = v.zt;
    intmask = v.im; hint_beg = v.hb; vint_beg = v.vb;
    @(posedge clk);
    #1;
    check({v.name, ".int_start"}, 32'(int_start), 32'(v.e_st));
    check({v.name, ".int_n"},     32'(int_n),     32'(v.e_n));
    check({v.name, ".int_vect"},  32'(int_vect),  32'(v.e_vect));
    check({v.name, ".pend"},      32'(pend),      32'(v.e_pend));
  endtask

  initial begin
    res_n = 1'b0;
    zclk_tick = 0; line_start = 0; frame_start = 0; col_tick = 0;
    dma_end = 0; intack = 0; intmask = 3'b001; hint_beg = 8'd1; vint_beg = 9'd0;

    // A: frame INT with timeout (intmask=001, vint_beg=0, hint_beg=1)
    vecs.push_back(mk("A_fs",   1,1,0,0,0,0, 3'b001, 8'd1, 9'd0, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("A_col1", 0,0,1,0,0,0, 3'b001, 8'd1, 9'd0, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("A_hit",  0,0,1,0,0,0, 3'b001, 8'd1, 9'd0, 1,0,8'hFF,3'b001));
    vecs.push_back(mk("A_idle", 0,0,0,0,0,0, 3'b001, 8'd1, 9'd0, 0,0,8'hFF,3'b001));
    for (int i = 0; i < 31; i++)
      vecs.push_back(mk("A_tick", 0,0,0,0,0,1, 3'b001, 8'd1, 9'd0, 0,0,8'hFF,3'b001));
    vecs.push_back(mk("A_tmo",  0,0,0,0,0,1, 3'b001, 8'd1, 9'd0, 0,1,8'hFF,3'b000));

    // B: masked frame INT still pulses int_start on line 5
    vecs.push_back(mk("B_fs",   1,1,0,0,0,0, 3'b000, 8'd1, 9'd5, 0,1,8'hFF,3'b000));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("B_ls", 0,1,0,0,0,0, 3'b000, 8'd1, 9'd5, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("B_col1", 0,0,1,0,0,0, 3'b000, 8'd1, 9'd5, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("B_hit",  0,0,1,0,0,0, 3'b000, 8'd1, 9'd5, 1,1,8'hFF,3'b000));
    vecs.push_back(mk("B_idle", 0,0,0,0,0,0, 3'b000, 8'd1, 9'd5, 0,1,8'hFF,3'b000));

    // C: line INT at 4th col_tick (hint_beg=3), ack, no timeout
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk("C_ls", 0,1,0,0,0,0, 3'b010, 8'd3, 9'd5, 0,1,8'hFF,3'b000));
      for (int i = 0; i < 3; i++)
        vecs.push_back(mk("C_col", 0,0,1,0,0,0, 3'b010, 8'd3, 9'd5, 0,1,8'hFF,3'b000));
      vecs.push_back(mk("C_hit", 0,0,1,0,0,0, 3'b010, 8'd3, 9'd5, 0,0,8'hFD,3'b010));
      if (r == 1)
        for (int i = 0; i < 100; i++)
          vecs.push_back(mk("C_tick", 0,0,0,0,0,1, 3'b010, 8'd3, 9'd5, 0,0,8'hFD,3'b010));
      vecs.push_back(mk("C_ack", 0,0,0,0,1,0, 3'b010, 8'd3, 9'd5, 0,1,8'hFF,3'b000));
    end

    // D: frame and DMA pending, acked in priority order
    vecs.push_back(mk("D_fs",   1,1,0,0,0,0, 3'b111, 8'd0, 9'd0, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("D_dma",  0,0,0,1,0,0, 3'b111, 8'd0, 9'd0, 0,0,8'hFB,3'b100));
    vecs.push_back(mk("D_hit",  0,0,1,0,0,0, 3'b111, 8'd0, 9'd0, 1,0,8'hFF,3'b101));
    vecs.push_back(mk("D_ack1", 0,0,0,0,1,0, 3'b111, 8'd0, 9'd0, 0,0,8'hFB,3'b100));
    vecs.push_back(mk("D_ack2", 0,0,0,0,1,0, 3'b111, 8'd0, 9'd0, 0,1,8'hFF,3'b000));

    // E: set beats ack, mask clear, ack with nothing pending
    vecs.push_back(mk("E_dma",  0,0,0,1,0,0, 3'b111, 8'd0, 9'd0, 0,0,8'hFB,3'b100));
    vecs.push_back(mk("E_both", 0,0,0,1,1,0, 3'b111, 8'd0, 9'd0, 0,0,8'hFB,3'b100));
    vecs.push_back(mk("E_mask", 0,0,0,0,0,0, 3'b011, 8'd0, 9'd0, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("E_ack0", 0,0,0,0,1,0, 3'b011, 8'd0, 9'd0, 0,1,8'hFF,3'b000));

    // F: masked line hit ignored, then DMA pending ahead of reset
    vecs.push_back(mk("F_ls",   0,1,0,0,0,0, 3'b100, 8'd0, 9'd0, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("F_col",  0,0,1,0,0,0, 3'b100, 8'd0, 9'd0, 0,1,8'hFF,3'b000));
    vecs.push_back(mk("F_dma",  0,0,0,1,0,0, 3'b100, 8'd0, 9'd0, 0,0,8'hFB,3'b100));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.int_start", 32'(int_start), 32'd0);
    check("rst.int_n",     32'(int_n),     32'd1);
    check("rst.int_vect",  32'(int_vect),  32'hFF);
    check("rst.pend",      32'(pend),      32'd0);
    @(negedge clk);
    res_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Async reset while /INT is low: no clock edge before the check
    check("pre_rst.int_n", 32'(int_n), 32'd0);
    check("pre_rst.vcnt",  32'(dut.u_pos.vcnt), 32'd1);
    @(negedge clk);
    dma_end = 0; col_tick = 0; line_start = 0;
    res_n = 1'b0;
    #1;
    check("arst.int_n", 32'(int_n), 32'd1);
    check("arst.pend",  32'(pend),  32'd0);
    check("arst.hcnt",  32'(dut.u_pos.hcnt), 32'd0);
    check("arst.vcnt",  32'(dut.u_pos.vcnt), 32'd0);
    @(negedge clk);
    res_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
